ahb_lite_arbiter: RTL and testbench

//  Two-master input stage and arbiter for the shared AHB-Lite bus. Muxes M0/M1 address/control
//  and write data onto one bus that feeds AHB_Lite_decoder and slaves 0-3. Holds a losing

---
 rtl/ahb_lite_arbiter_pkg.sv | 30 +++
 rtl/ahb_lite_hold_reg.sv | 85 ++++++++
 rtl/ahb_lite_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_ahb_lite_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_arbiter_pkg.sv
// rtl/ahb_lite_arbiter_pkg.sv - shared AHB-Lite encodings and master-select helpers for the arbiter
package ahb_lite_arbiter_pkg;

  localparam int BUS_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic {
    MST0 = 1'b0,
    MST1 = 1'b1
  } mst_e;

  // NONSEQ and SEQ are the only encodings that move data.
  function automatic logic trans_active(input logic [1:0] trans);
    return trans[1];
  endfunction

  function automatic mst_e other_mst(input mst_e m);
    return (m == MST0) ? MST1 : MST0;
  endfunction

endpackage

// File: rtl/ahb_lite_hold_reg.sv
// rtl/ahb_lite_hold_reg.sv - one-entry register holding a master's accepted but not yet issued address phase
// A new capture is only possible while the entry is empty, since the master is stalled while it is full.
module ahb_lite_hold_reg
  import ahb_lite_arbiter_pkg::*;
#(
  parameter int ADDR_W = BUS_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              capture_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] haddr_i,
  input  logic [1:0]        htrans_i,
  input  logic              hwrite_i,
  input  logic [2:0]        hsize_i,
  input  logic [2:0]        hburst_i,
  input  logic              hmastlock_i,
  output logic              pend_v_o,
  output logic [ADDR_W-1:0] pend_addr_o,
  output logic [1:0]        pend_trans_o,
  output logic              pend_write_o,
  output logic [2:0]        pend_size_o,
  output logic [2:0]        pend_burst_o,
  output logic              pend_lock_o
);

  logic              pend_v_q,     pend_v_d;
  logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;
  logic [1:0]        pend_trans_q, pend_trans_d;
  logic              pend_write_q, pend_write_d;
  logic [2:0]        pend_size_q,  pend_size_d;
  logic [2:0]        pend_burst_q, pend_burst_d;
  logic              pend_lock_q,  pend_lock_d;

  always_comb begin
    pend_v_d     = pend_v_q;
    pend_addr_d  = pend_addr_q;
    pend_trans_d = pend_trans_q;
    pend_write_d = pend_write_q;
    pend_size_d  = pend_size_q;
    pend_burst_d = pend_burst_q;
    pend_lock_d  = pend_lock_q;
    if (issue_i) begin
      pend_v_d = 1'b0;
    end
    if (capture_i) begin
      pend_v_d     = 1'b1;
      pend_addr_d  = haddr_i;
      pend_trans_d = htrans_i;
      pend_write_d = hwrite_i;
      pend_size_d  = hsize_i;
      pend_burst_d = hburst_i;
      pend_lock_d  = hmastlock_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_v_q     <= 1'b0;
      pend_addr_q  <= '0;
      pend_trans_q <= HTRANS_IDLE;
      pend_write_q <= 1'b0;
      pend_size_q  <= '0;
      pend_burst_q <= HBURST_SINGLE;
      pend_lock_q  <= 1'b0;
    end else begin
      pend_v_q     <= pend_v_d;
      pend_addr_q  <= pend_addr_d;
      pend_trans_q <= pend_trans_d;
      pend_write_q <= pend_write_d;
      pend_size_q  <= pend_size_d;
      pend_burst_q <= pend_burst_d;
      pend_lock_q  <= pend_lock_d;
    end
  end

  assign pend_v_o     = pend_v_q;
  assign pend_addr_o  = pend_addr_q;
  assign pend_trans_o = pend_trans_q;
  assign pend_write_o = pend_write_q;
  assign pend_size_o  = pend_size_q;
  assign pend_burst_o = pend_burst_q;
  assign pend_lock_o  = pend_lock_q;

endmodule

// File: rtl/ahb_lite_arbiter.sv
// rtl/ahb_lite_arbiter.sv - two-master AHB-Lite input stage and round-robin arbiter onto one shared bus
// Live requests are granted with zero latency; a losing master's address phase is parked in a hold register.
module ahb_lite_arbiter
  import ahb_lite_arbiter_pkg::*;
#(
  parameter int ADDR_W = BUS_WIDTH,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [2:0]        M0_HBURST,
  input  logic              M0_HMASTLOCK,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic [DATA_W-1:0] M0_HRDATA,
  output logic              M0_HREADY,
  output logic              M0_HRESP,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [2:0]        M1_HBURST,
  input  logic              M1_HMASTLOCK,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic [DATA_W-1:0] M1_HRDATA,
  output logic              M1_HREADY,
  output logic              M1_HRESP,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  logic [ADDR_W-1:0] live_addr [2];
  logic [1:0]        live_trans[2];
  logic              live_write[2];
  logic [2:0]        live_size [2];
  logic [2:0]        live_burst[2];
  logic              live_lock [2];

  logic [ADDR_W-1:0] pend_addr [2];
  logic [1:0]        pend_trans[2];
  logic              pend_write[2];
  logic [2:0]        pend_size [2];
  logic [2:0]        pend_burst[2];
  logic              pend_lock [2];
  logic [1:0]        pend_v;

  logic [ADDR_W-1:0] src_addr [2];
  logic [1:0]        src_trans[2];
  logic              src_write[2];
  logic [2:0]        src_size [2];
  logic [2:0]        src_burst[2];
  logic              src_lock [2];

  logic [1:0] own_dp;
  logic [1:0] mst_ready;
  logic [1:0] live_req;
  logic [1:0] req;
  logic [1:0] capture;
  logic [1:0] issue;

  mst_e addr_own_q, addr_own_d;
  mst_e data_own_q, data_own_d;
  mst_e rr_ptr_q,   rr_ptr_d;
  logic burst_hold_q, burst_hold_d;
  logic data_v_q,     data_v_d;

  mst_e grant;
  logic bus_show;

  assign live_addr[0]  = M0_HADDR;
  assign live_trans[0] = M0_HTRANS;
  assign live_write[0] = M0_HWRITE;
  assign live_size[0]  = M0_HSIZE;
  assign live_burst[0] = M0_HBURST;
  assign live_lock[0]  = M0_HMASTLOCK;
  assign live_addr[1]  = M1_HADDR;
  assign live_trans[1] = M1_HTRANS;
  assign live_write[1] = M1_HWRITE;
  assign live_size[1]  = M1_HSIZE;
  assign live_burst[1] = M1_HBURST;
  assign live_lock[1]  = M1_HMASTLOCK;

  assign own_dp[0] = data_v_q && (data_own_q == MST0);
  assign own_dp[1] = data_v_q && (data_own_q == MST1);

  for (genvar g = 0; g < 2; g++) begin : g_mst
    // A held entry stalls its master until the entry has been issued.
    assign mst_ready[g] = !pend_v[g] && (own_dp[g] ? HREADY : 1'b1);
    assign live_req[g]  = HRESETn && trans_active(live_trans[g]) && mst_ready[g];
    assign req[g]       = pend_v[g] || live_req[g];
    assign capture[g]   = live_req[g] && !(HREADY && (grant == mst_e'(g)));
    assign issue[g]     = HREADY && trans_active(HTRANS) && (grant == mst_e'(g)) && pend_v[g];

    assign src_addr[g]  = pend_v[g] ? pend_addr[g]  : live_addr[g];
    assign src_trans[g] = pend_v[g] ? pend_trans[g] : live_trans[g];
    assign src_write[g] = pend_v[g] ? pend_write[g] : live_write[g];
    assign src_size[g]  = pend_v[g] ? pend_size[g]  : live_size[g];
    assign src_burst[g] = pend_v[g] ? pend_burst[g] : live_burst[g];
    assign src_lock[g]  = pend_v[g] ? pend_lock[g]  : live_lock[g];

    ahb_lite_hold_reg #(
      .ADDR_W (ADDR_W)
    ) u_hold (
      .clk_i        (HCLK),
      .rst_ni       (HRESETn),
      .capture_i    (capture[g]),
      .issue_i      (issue[g]),
      .haddr_i      (live_addr[g]),
      .htrans_i     (live_trans[g]),
      .hwrite_i     (live_write[g]),
      .hsize_i      (live_size[g]),
      .hburst_i     (live_burst[g]),
      .hmastlock_i  (live_lock[g]),
      .pend_v_o     (pend_v[g]),
      .pend_addr_o  (pend_addr[g]),
      .pend_trans_o (pend_trans[g]),
      .pend_write_o (pend_write[g]),
      .pend_size_o  (pend_size[g]),
      .pend_burst_o (pend_burst[g]),
      .pend_lock_o  (pend_lock[g])
    );
  end

  always_comb begin
    grant = addr_own_q;
    if (HREADY && !burst_hold_q) begin
      if (req[0] && req[1]) begin
        grant = rr_ptr_q;
      end else if (req[0]) begin
        grant = MST0;
      end else if (req[1]) begin
        grant = MST1;
      end
    end
  end

  // Inside a held burst the owner's BUSY/IDLE is forwarded untouched; during wait states the owner's phase is held.
  assign bus_show  = HRESETn && (burst_hold_q || !HREADY || req[grant]);
  assign HTRANS    = bus_show ? src_trans[grant] : HTRANS_IDLE;
  assign HADDR     = src_addr[grant];
  assign HWRITE    = src_write[grant];
  assign HSIZE     = src_size[grant];
  assign HBURST    = src_burst[grant];
  assign HMASTLOCK = src_lock[grant];
  assign HWDATA    = (data_own_q == MST1) ? M1_HWDATA : M0_HWDATA;

  assign M0_HREADY = mst_ready[0];
  assign M1_HREADY = mst_ready[1];
  assign M0_HRESP  = own_dp[0] ? HRESP : HRESP_OKAY;
  assign M1_HRESP  = own_dp[1] ? HRESP : HRESP_OKAY;
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;

  always_comb begin
    addr_own_d   = addr_own_q;
    data_own_d   = data_own_q;
    rr_ptr_d     = rr_ptr_q;
    burst_hold_d = burst_hold_q;
    data_v_d     = data_v_q;
    if (HREADY) begin
      addr_own_d = grant;
      data_own_d = grant;
      data_v_d   = trans_active(HTRANS);
      case (HTRANS)
        HTRANS_IDLE: burst_hold_d = 1'b0;
        HTRANS_NONSEQ: begin
          burst_hold_d = (HBURST != HBURST_SINGLE) || HMASTLOCK;
          rr_ptr_d     = other_mst(grant);
        end
        default: burst_hold_d = burst_hold_q;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_own_q   <= MST0;
      data_own_q   <= MST0;
      rr_ptr_q     <= MST0;
      burst_hold_q <= 1'b0;
      data_v_q     <= 1'b0;
    end else begin
      addr_own_q   <= addr_own_d;
      data_own_q   <= data_own_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_hold_q <= burst_hold_d;
      data_v_q     <= data_v_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// tb/tb_ahb_lite_arbiter.sv - directed self-checking bench for ahb_lite_arbiter with an issue-order scoreboard
module tb_ahb_lite_arbiter;

  logic        hclk;
  logic        hresetn;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [2:0]  m0_hburst, m1_hburst;
  logic        m0_hmastlock, m1_hmastlock;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hready, m1_hready;
  logic        m0_hresp, m1_hresp;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_ent;

  ahb_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(hclk), .HRESETn(hresetn),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
    .M0_HBURST(m0_hburst), .M0_HMASTLOCK(m0_hmastlock), .M0_HWDATA(m0_hwdata),
    .M0_HRDATA(m0_hrdata), .M0_HREADY(m0_hready), .M0_HRESP(m0_hresp),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
    .M1_HBURST(m1_hburst), .M1_HMASTLOCK(m1_hmastlock), .M1_HWDATA(m1_hwdata),
    .M1_HRDATA(m1_hrdata), .M1_HREADY(m1_hready), .M1_HRESP(m1_hresp),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic drv(input int m, input logic [31:0] a, input logic [1:0] t, input logic w,
                     input logic [2:0] b, input logic l);
    if (m == 0) begin
      m0_haddr = a; m0_htrans = t; m0_hwrite = w; m0_hburst = b; m0_hmastlock = l;
    end else begin
      m1_haddr = a; m1_htrans = t; m1_hwrite = w; m1_hburst = b; m1_hmastlock = l;
    end
  endtask

  task automatic idle(input int m);
    drv(m, 32'h0, 2'b00, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic expect_issue(input logic [31:0] a, input logic w);
    exp_q.push_back({w, a});
  endtask

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  // Every address phase the bus accepts must match the next entry the directed steps queued.
  always @(negedge hclk) begin
    if (hresetn && hready && htrans[1]) begin
      chk1("issue_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_ent = exp_q.pop_front();
        chk("issue_addr", haddr, exp_ent[31:0]);
        chk1("issue_write", hwrite, exp_ent[32]);
      end
    end
  end

  initial begin
    hresetn = 1'b0;
    idle(0); idle(1);
    m0_hsize = 3'b010; m1_hsize = 3'b010;
    m0_hwdata = '0; m1_hwdata = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;

    // reset state
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_htrans", {30'b0, htrans}, 32'd0);
    chk1("rst_m0_hready", m0_hready, 1'b1);
    chk1("rst_m1_hready", m1_hready, 1'b1);
    chk1("rst_m0_hresp", m0_hresp, 1'b0);
    chk1("rst_m1_hresp", m1_hresp, 1'b0);
    next_cycle();
    hresetn = 1'b1;

    // both masters NONSEQ write in the first cycle: M0 wins, M1 held
    drv(0, 32'h1000_0000, 2'b10, 1'b1, 3'b000, 1'b0);
    drv(1, 32'h2000_0000, 2'b10, 1'b1, 3'b000, 1'b0);
    expect_issue(32'h1000_0000, 1'b1);
    @(negedge hclk);
    chk("t2_haddr0", haddr, 32'h1000_0000);
    chk1("t2_m0_hready0", m0_hready, 1'b1);
    next_cycle();
    drv(0, 32'h1000_0004, 2'b10, 1'b1, 3'b000, 1'b0);
    idle(1);
    m0_hwdata = 32'hAAAA_0001; m1_hwdata = 32'hBBBB_0001;
    expect_issue(32'h2000_0000, 1'b1);
    @(negedge hclk);
    chk1("t2_m1_held", m1_hready, 1'b0);
    chk("t2_haddr1", haddr, 32'h2000_0000);
    chk("t2_hwdata_m0", hwdata, 32'hAAAA_0001);
    chk1("t2_m0_hready1", m0_hready, 1'b1);
    next_cycle();
    idle(0);
    m0_hwdata = 32'hAAAA_0002;
    expect_issue(32'h1000_0004, 1'b1);
    @(negedge hclk);
    chk("t2_haddr2", haddr, 32'h1000_0004);
    chk("t2_hwdata_m1", hwdata, 32'hBBBB_0001);
    chk1("t2_m1_hready2", m1_hready, 1'b1);
    chk1("t2_m0_held", m0_hready, 1'b0);
    next_cycle();
    @(negedge hclk);
    chk("t2_hwdata_m0b", hwdata, 32'hAAAA_0002);
    chk1("t2_m0_hready3", m0_hready, 1'b1);
    next_cycle();

    // single M0 read, zero-latency address, read data broadcast
    drv(0, 32'h0000_0010, 2'b10, 1'b0, 3'b000, 1'b0);
    expect_issue(32'h0000_0010, 1'b0);
    @(negedge hclk);
    chk("t1_haddr", haddr, 32'h0000_0010);
    chk("t1_htrans", {30'b0, htrans}, 32'd2);
    chk1("t1_m0_hready", m0_hready, 1'b1);
    next_cycle();
    idle(0);
    hrdata = 32'hCAFE_F00D;
    @(negedge hclk);
    chk("t1_m0_hrdata", m0_hrdata, 32'hCAFE_F00D);
    chk1("t1_m0_hready_dp", m0_hready, 1'b1);
    next_cycle();
    hrdata = '0;

    // M0 INCR4 keeps the bus while M1 waits, M1 follows the burst
    drv(0, 32'h0000_0100, 2'b10, 1'b0, 3'b011, 1'b0);
    expect_issue(32'h0000_0100, 1'b0);
    next_cycle();
    drv(0, 32'h0000_0104, 2'b11, 1'b0, 3'b011, 1'b0);
    drv(1, 32'h3000_0000, 2'b10, 1'b0, 3'b000, 1'b0);
    expect_issue(32'h0000_0104, 1'b0);
    @(negedge hclk);
    chk("t3_beat1", haddr, 32'h0000_0104);
    next_cycle();
    drv(0, 32'h0000_0108, 2'b11, 1'b0, 3'b011, 1'b0);
    idle(1);
    expect_issue(32'h0000_0108, 1'b0);
    @(negedge hclk);
    chk1("t3_m1_held", m1_hready, 1'b0);
    next_cycle();
    drv(0, 32'h0000_010C, 2'b11, 1'b0, 3'b011, 1'b0);
    expect_issue(32'h0000_010C, 1'b0);
    next_cycle();
    idle(0);
    expect_issue(32'h3000_0000, 1'b0);
    repeat (3) next_cycle();
    @(negedge hclk);
    chk1("t3_m1_released", m1_hready, 1'b1);
    next_cycle();

    // two wait states on M0's data phase with M1 held behind it
    drv(0, 32'h4000_0000, 2'b10, 1'b1, 3'b000, 1'b0);
    drv(1, 32'h5000_0000, 2'b10, 1'b0, 3'b000, 1'b0);
    expect_issue(32'h4000_0000, 1'b1);
    expect_issue(32'h5000_0000, 1'b0);
    next_cycle();
    idle(0); idle(1);
    hready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge hclk);
      chk1("t4_m0_wait", m0_hready, 1'b0);
      chk1("t4_m1_wait", m1_hready, 1'b0);
      next_cycle();
    end
    hready = 1'b1;
    @(negedge hclk);
    chk1("t4_m0_done", m0_hready, 1'b1);
    chk("t4_m1_issue", haddr, 32'h5000_0000);
    next_cycle();
    @(negedge hclk);
    chk1("t4_m1_dp", m1_hready, 1'b1);
    next_cycle();

    // two-cycle ERROR response on M1's data phase
    drv(1, 32'h6000_0000, 2'b10, 1'b0, 3'b000, 1'b0);
    expect_issue(32'h6000_0000, 1'b0);
    next_cycle();
    idle(1);
    hready = 1'b0; hresp = 1'b1;
    @(negedge hclk);
    chk1("t5_m1_hresp1", m1_hresp, 1'b1);
    chk1("t5_m0_hresp1", m0_hresp, 1'b0);
    chk1("t5_m1_hready1", m1_hready, 1'b0);
    next_cycle();
    hready = 1'b1;
    @(negedge hclk);
    chk1("t5_m1_hresp2", m1_hresp, 1'b1);
    chk1("t5_m0_hresp2", m0_hresp, 1'b0);
    chk1("t5_m1_hready2", m1_hready, 1'b1);
    next_cycle();
    hresp = 1'b0;
    @(negedge hclk);
    chk1("t5_m1_hresp3", m1_hresp, 1'b0);
    next_cycle();

    // reset in the middle of a burst with M1 held
    drv(0, 32'h0000_0700, 2'b10, 1'b0, 3'b011, 1'b0);
    expect_issue(32'h0000_0700, 1'b0);
    next_cycle();
    drv(0, 32'h0000_0704, 2'b11, 1'b0, 3'b011, 1'b0);
    drv(1, 32'h8000_0000, 2'b10, 1'b0, 3'b000, 1'b0);
    expect_issue(32'h0000_0704, 1'b0);
    next_cycle();
    drv(0, 32'h0000_0708, 2'b11, 1'b0, 3'b011, 1'b0);
    idle(1);
    hresetn = 1'b0;
    @(negedge hclk);
    chk("t6_htrans", {30'b0, htrans}, 32'd0);
    chk1("t6_m0_hready", m0_hready, 1'b1);
    chk1("t6_m1_hready", m1_hready, 1'b1);
    next_cycle();
    idle(0);
    hresetn = 1'b1;
    @(negedge hclk);
    chk("t6_no_stale_issue", {30'b0, htrans}, 32'd0);
    chk1("t6_m1_clear", m1_hready, 1'b1);
    repeat (2) next_cycle();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
